// File: rtl/lu_pkg.sv
// Shared types for the logic-slot issue path: operation record and select encodings.
package lu_pkg;

    localparam int LU_SEL_W = 3;
    localparam int LU_WIDTH = 32;
    localparam int LU_TAG_W = 5;

    typedef struct packed {
        logic [LU_WIDTH-1:0] a;
        logic [LU_WIDTH-1:0] b;
        logic [LU_SEL_W-1:0] s;
        logic [LU_TAG_W-1:0] tag;
    } lu_op_t;

    // Select encodings understood by the logic unit and produced by the decoder.
    typedef enum logic [LU_SEL_W-1:0] {
        LU_SEL_AND  = 3'd0,
        LU_SEL_OR   = 3'd1,
        LU_SEL_XOR  = 3'd2,
        LU_SEL_NAND = 3'd3,
        LU_SEL_NOR  = 3'd4,
        LU_SEL_XNOR = 3'd5,
        LU_SEL_ANDN = 3'd6,
        LU_SEL_PASA = 3'd7
    } lu_sel_e;

    function automatic int lu_op_bits(input int width, input int tag_w);
        return 2 * width + LU_SEL_W + tag_w;
    endfunction

endpackage

// File: rtl/lu_fifo.sv
// Circular buffer holding decoded logic operations between decoder and output register.
module lu_fifo #(
    parameter int DW    = 72,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [DW-1:0]              wdata_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lu_issue_stage.sv
// Issue stage feeding the logic unit: FIFO plus registered output stage.
// Optional input-to-output bypass on an empty stage: LU_ISSUE_BYPASS_EN.
module lu_issue_stage
    import lu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [LU_SEL_W-1:0]    in_s,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   flush,
    output logic                   lu_valid,
    input  logic                   lu_ready,
    output logic [WIDTH-1:0]       lu_a,
    output logic [WIDTH-1:0]       lu_b,
    output logic [LU_SEL_W-1:0]    lu_s,
    output logic [TAG_W-1:0]       lu_tag,
    output logic [$clog2(DEPTH):0] count
);
    localparam int OP_W = lu_op_bits(WIDTH, TAG_W);

    logic [OP_W-1:0] in_op, fifo_rdata;
    logic [OP_W-1:0] lu_op_d, lu_op_q;
    logic            lu_valid_d, lu_valid_q;
    logic            fifo_full, fifo_empty;
    logic            load, bypass, push, pop;

    assign in_op    = {in_a, in_b, in_s, in_tag};
    assign in_ready = !fifo_full;
    assign load     = !lu_valid_q || lu_ready;

`ifdef LU_ISSUE_BYPASS_EN
    assign bypass = fifo_empty && load && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = load && !fifo_empty && !flush;

    lu_fifo #(
        .DW    (OP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (in_op),
        .rdata_o (fifo_rdata),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FIFO head has precedence over bypass so ordering is preserved.
    always_comb begin
        lu_valid_d = lu_valid_q;
        lu_op_d    = lu_op_q;
        if (flush) begin
            lu_valid_d = 1'b0;
        end else if (load) begin
            if (!fifo_empty) begin
                lu_valid_d = 1'b1;
                lu_op_d    = fifo_rdata;
            end else if (bypass) begin
                lu_valid_d = 1'b1;
                lu_op_d    = in_op;
            end else begin
                lu_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_valid_q <= 1'b0;
            lu_op_q    <= '0;
        end else begin
            lu_valid_q <= lu_valid_d;
            lu_op_q    <= lu_op_d;
        end
    end

    assign lu_valid = lu_valid_q;
    assign {lu_a, lu_b, lu_s, lu_tag} = lu_op_q;

endmodule

// File: tb/tb_lu_issue_stage.sv
// Scoreboard bench for lu_issue_stage; honours LU_ISSUE_BYPASS_EN for latency expectations.
module tb_lu_issue_stage;
    import lu_pkg::*;

`ifdef LU_ISSUE_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [2:0]  in_s = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        lu_valid;
    logic        lu_ready = 1'b0;
    logic [31:0] lu_a, lu_b;
    logic [2:0]  lu_s;
    logic [4:0]  lu_tag;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    lu_op_t pend_q[$];
    lu_op_t exp_q[$];
    lu_op_t obs_q[$];
    int     ocyc_q[$];

    lu_issue_stage #(.WIDTH(32), .DEPTH(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag), .flush(flush),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_a(lu_a), .lu_b(lu_b),
        .lu_s(lu_s), .lu_tag(lu_tag), .count(count)
    );

    always #5 clk = ~clk;

    // Accepted ops wait in pend_q; each consumption moves the oldest to exp_q.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (lu_valid && lu_ready && !flush) begin
                obs_q.push_back(lu_op_t'({lu_a, lu_b, lu_s, lu_tag}));
                ocyc_q.push_back(cyc);
                if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
                else                   exp_q.push_back(lu_op_t'('x));
            end
            if (flush) pend_q.delete();
            else if (in_valid && in_ready) pend_q.push_back(lu_op_t'({in_a, in_b, in_s, in_tag}));
        end
    end

    function automatic lu_op_t mk(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] s, input logic [4:0] tag);
        lu_op_t op;
        op.a = a; op.b = b; op.s = s; op.tag = tag;
        return op;
    endfunction

    // Called at a negedge; returns at the negedge after the op was accepted.
    task automatic push_op(input lu_op_t op, output bit ok);
        int w = 0;
        in_valid = 1'b1;
        {in_a, in_b, in_s, in_tag} = op;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 50);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((pend_q.size() != 0 || lu_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
    endtask

    task automatic clear_sb();
        pend_q.delete(); exp_q.delete(); obs_q.delete(); ocyc_q.delete();
    endtask

    task automatic test_reset();
        n_cmp++; if (lu_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", lu_valid); end
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({lu_a, lu_b, lu_s, lu_tag} !== 72'd0)
            begin n_mis++; $display("FAIL reset_outputs: got %h want 0", {lu_a, lu_b, lu_s, lu_tag}); end
    endtask

    task automatic test_single();
        lu_op_t o, e;
        bit ok;
        int lat;
        clear_sb();
        lu_ready = 1'b1;
        push_op(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd3, 5'd7), ok);
        lat = 1;
        while (!lu_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != EXP_LAT) begin n_mis++; $display("FAIL single_latency: got %0d want %0d", lat, EXP_LAT); end
        n_cmp++; if (lu_a !== 32'hF0F0_F0F0) begin n_mis++; $display("FAIL single_a: got %h want f0f0f0f0", lu_a); end
        n_cmp++; if (lu_b !== 32'h0FF0_0FF0) begin n_mis++; $display("FAIL single_b: got %h want 0ff00ff0", lu_b); end
        n_cmp++; if (lu_s !== 3'd3) begin n_mis++; $display("FAIL single_s: got %0d want 3", lu_s); end
        n_cmp++; if (lu_tag !== 5'd7) begin n_mis++; $display("FAIL single_tag: got %0d want 7", lu_tag); end
        drain(ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL single_drain: timeout got 0 want 1"); end
        n_cmp++; if (obs_q.size() != 1) begin n_mis++; $display("FAIL single_n: got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e) begin n_mis++; $display("FAIL single_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_stall();
        lu_op_t o, e;
        bit ok;
        int k = 0;
        clear_sb();
        lu_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(mk(32'h1000 + i, 32'h2000 + i, 3'(i), 5'(i + 1)), ok);
        in_valid = 1'b1;
        {in_a, in_b, in_s, in_tag} = mk(32'h1005, 32'h2005, 3'd5, 5'd6);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL stall_count: got %0d want 4", count); end
            n_cmp++; if (!(lu_valid === 1'b1 && lu_s === 3'd0 && lu_a === 32'h1000))
                begin n_mis++; $display("FAIL stall_hold: got v=%b s=%0d a=%h want v=1 s=0 a=1000", lu_valid, lu_s, lu_a); end
            @(negedge clk);
        end
        lu_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1)
            begin n_mis++; $display("FAIL stall_pop_full: got count=%0d rdy=%b want 3 1", count, in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        drain(ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL stall_drain: timeout got 0 want 1"); end
        n_cmp++; if (obs_q.size() != 6) begin n_mis++; $display("FAIL stall_n: got %0d want 6", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e || o.s !== 3'(k))
                begin n_mis++; $display("FAIL stall_sb: got %h want %h s=%0d", o, e, k); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        lu_op_t o, e;
        bit ok;
        int k = 0;
        int c0, c1;
        clear_sb();
        lu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_op(mk($urandom, $urandom, 3'(i), 5'(20 + i)), ok);
            n_cmp++; if (count > 3'd1) begin n_mis++; $display("FAIL b2b_count: got %0d want <=1", count); end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_mis++; $display("FAIL b2b_drain: timeout got 0 want 1"); end
        n_cmp++; if (obs_q.size() != 8) begin n_mis++; $display("FAIL b2b_n: got %0d want 8", obs_q.size()); end
        if (ocyc_q.size() == 8) begin
            c0 = ocyc_q[0]; c1 = ocyc_q[7];
            n_cmp++; if (c1 - c0 != 7) begin n_mis++; $display("FAIL b2b_rate: got %0d cycles want 7", c1 - c0); end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o !== e || o.s !== 3'(k))
                begin n_mis++; $display("FAIL b2b_sb: got %h want %h s=%0d", o, e, k); end
            k++;
        end
    endtask

    task automatic test_flush();
        bit ok;
        clear_sb();
        lu_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_op(mk(32'hA0 + i, 32'hB0 + i, 3'(i), 5'(10 + i)), ok);
        n_cmp++; if (count !== 3'd3 || lu_valid !== 1'b1)
            begin n_mis++; $display("FAIL flush_setup: got count=%0d v=%b want 3 1", count, lu_valid); end
        flush = 1'b1;
        in_valid = 1'b1;
        {in_a, in_b, in_s, in_tag} = mk(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd7, 5'd31);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (lu_valid !== 1'b0) begin n_mis++; $display("FAIL flush_valid: got %b want 0", lu_valid); end
        lu_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0 || lu_valid !== 1'b0)
            begin n_mis++; $display("FAIL flush_leak: got %0d ops want 0", obs_q.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_sb();
        lu_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_op(mk(32'h55 + i, 32'h66 + i, 3'(i + 2), 5'(i + 3)), ok);
        #2 rst = 1'b1;
        #1;
        clear_sb();
        n_cmp++; if (lu_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
            begin n_mis++; $display("FAIL areset_ctl: got v=%b c=%0d r=%b want 0 0 1", lu_valid, count, in_ready); end
        n_cmp++; if ({lu_a, lu_b, lu_s, lu_tag} !== 72'd0)
            begin n_mis++; $display("FAIL areset_data: got %h want 0", {lu_a, lu_b, lu_s, lu_tag}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
